serial_adder: RTL and testbench

//   Bit-serial ripple adder: accepts two WIDTH-bit operands plus carry-in,

---
 rtl/serial_adder.sv | 121 ++++++++++++
 tb/tb_serial_adder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial adder. Adds two WIDTH-bit operands plus carry-in
//            LSB-first through one full-adder cell and a registered carry.
// Revision : 1.0  initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-2:0]   r_sum_sh;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_load;
    logic               w_shift;
    logic               w_last;
    logic               w_bit;
    logic               w_carry;
    logic [WIDTH-1:0]   w_sum_next;

    // One full-adder cell; its sum bit enters the accumulated sum from the top.
    assign w_bit      = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_carry    = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);
    assign w_sum_next = {w_bit, r_sum_sh};
    assign w_last     = (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake outputs depend on state only; the unused encoding acts as IDLE.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            S_SHIFT: begin
                w_shift = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
        end else if (w_load) begin
            r_a_sh  <= a_in;
            r_b_sh  <= b_in;
            r_carry <= cin_in;
            r_cnt   <= '0;
        end else if (w_shift) begin
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_sum_sh <= w_sum_next[WIDTH-1:1];
            r_carry  <= w_carry;
            if (w_last) begin
                sum_out  <= w_sum_next;
                cout_out <= w_carry;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=4.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       iv8, ir8, ov8, or8, cin8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       or8_man, rnd8 = 1'b1, stall8_en;

    logic       iv4, ir4, ov4, or4, cin4, cout4;
    logic [3:0] a4, b4, sum4;
    logic       or4_man, rnd4 = 1'b1, stall4_en;

    assign or8 = stall8_en ? rnd8 : or8_man;
    assign or4 = stall4_en ? rnd4 : or4_man;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .a_in(a8), .b_in(b8), .cin_in(cin8),
        .out_valid(ov8), .out_ready(or8), .sum_out(sum8), .cout_out(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4), .a_in(a4), .b_in(b4), .cin_in(cin4),
        .out_valid(ov4), .out_ready(or4), .sum_out(sum4), .cout_out(cout4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] res;
        int         cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    exp_t e8, e4;
    int   checks = 0, errors = 0, cyc = 0;
    int   acc8 = 0, res8 = 0, acc4 = 0, res4 = 0;
    logic prev8 = 1'b0, prev4 = 1'b0;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rnd8 <= ($urandom_range(0, 2) != 0);
        rnd4 <= ($urandom_range(0, 2) != 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or event not expected", name);
    endtask

    // Monitors: latency on the rising edge of out_valid, data on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev8 = 1'b0;
        end else begin
            if (ov8 && !prev8) begin
                if (q8.size() == 0) flag("w8_unexpected_valid");
                else check("w8_latency", 32'(cyc - q8[0].cyc), 32'd8);
            end
            if (ov8 && or8 && q8.size() != 0) begin
                e8 = q8.pop_front();
                check("w8_sum", 32'(sum8), 32'(e8.res[7:0]));
                check("w8_cout", 32'(cout8), 32'(e8.res[8]));
                res8++;
            end
            prev8 = ov8;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev4 = 1'b0;
        end else begin
            if (ov4 && !prev4) begin
                if (q4.size() == 0) flag("w4_unexpected_valid");
                else check("w4_latency", 32'(cyc - q4[0].cyc), 32'd4);
            end
            if (ov4 && or4 && q4.size() != 0) begin
                e4 = q4.pop_front();
                check("w4_sum", 32'(sum4), 32'(e4.res[3:0]));
                check("w4_cout", 32'(cout4), 32'(e4.res[4]));
                res4++;
            end
            prev4 = ov4;
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int n = 0;
        @(negedge clk);
        while (!ir8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ir8) begin
            flag("w8_accept_timeout");
            return;
        end
        a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        q8.push_back('{res: 9'(a) + 9'(b) + 9'(c), cyc: cyc});
        acc8++;
    endtask

    task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic c);
        int n = 0;
        @(negedge clk);
        while (!ir4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ir4) begin
            flag("w4_accept_timeout");
            return;
        end
        a4 = a; b4 = b; cin4 = c; iv4 = 1'b1;
        @(posedge clk);
        #1;
        iv4 = 1'b0;
        q4.push_back('{res: 9'(5'(a) + 5'(b) + 5'(c)), cyc: cyc});
        acc4++;
    endtask

    task automatic drain8();
        int n = 0;
        while (q8.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q8.size() != 0) flag("w8_drain_timeout");
    endtask

    task automatic drain4();
        int n = 0;
        while (q4.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q4.size() != 0) flag("w4_drain_timeout");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    initial begin
        int r0;
        int n;
        rst_n = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; or8_man = 1'b1; stall8_en = 1'b0;
        iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; or4_man = 1'b1; stall4_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready8", 32'(ir8), 32'd1);
        check("rst_out_valid8", 32'(ov8), 32'd0);
        check("rst_sum8", 32'(sum8), 32'd0);
        check("rst_cout8", 32'(cout8), 32'd0);
        check("rst_in_ready4", 32'(ir4), 32'd1);
        check("rst_out_valid4", 32'(ov4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send8(8'h3C, 8'h5A, 1'b0);
        send8(8'hFF, 8'h01, 1'b0);
        send8(8'hFF, 8'hFF, 1'b1);
        drain8();

        // Backpressure: 0x80 + 0x80 + 1 = 0x101
        or8_man = 1'b0;
        send8(8'h80, 8'h80, 1'b1);
        n = 0;
        while (!ov8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ov8) flag("bp_wait_valid");
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", 32'(ov8), 32'd1);
            check("bp_in_ready", 32'(ir8), 32'd0);
            check("bp_sum", 32'(sum8), 32'h01);
            check("bp_cout", 32'(cout8), 32'd1);
        end
        @(posedge clk);
        #1;
        or8_man = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 32'(ir8), 32'd1);
        check("bp_release_out_valid", 32'(ov8), 32'd0);
        check("bp_idle_sum_held", 32'(sum8), 32'h01);
        drain8();

        // in_valid pulsed mid-SHIFT must not start a second add
        r0 = res8;
        send8(8'h12, 8'h34, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; iv8 = 1'b1;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        drain8();
        repeat (12) @(posedge clk);
        #1;
        check("ignore_txn_count", 32'(res8 - r0), 32'd1);

        // Reset at cnt=3 of SHIFT
        send8(8'hC3, 8'h77, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(ir8), 32'd1);
        check("midrst_out_valid", 32'(ov8), 32'd0);
        check("midrst_sum", 32'(sum8), 32'd0);
        check("midrst_cout", 32'(cout8), 32'd0);
        acc8 -= q8.size();
        q8.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send8(8'h10, 8'h20, 1'b0);
        drain8();

        stall8_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send8(8'($urandom), 8'($urandom), 1'($urandom));
        end
        drain8();
        stall8_en = 1'b0;

        stall4_en = 1'b1;
        for (int i = 0; i < 512; i++) begin
            send4(4'(i), 4'(i >> 4), 1'(i >> 8));
        end
        drain4();
        stall4_en = 1'b0;

        repeat (12) @(posedge clk);
        #1;
        check("w8_txn_count", 32'(res8), 32'(acc8));
        check("w4_txn_count", 32'(res4), 32'd512);
        check("w4_accepted", 32'(acc4), 32'd512);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
